// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle instruction sequencer for the 9-bit core. It owns the PC and
//   the instruction register, fetches through a req/ack port, and steps the
//   datapath through DECODE, EXEC, MEM (loads/stores only) and WB.
//
// Parameters
//   PC_W        program counter width (PC arithmetic wraps modulo 2^PC_W)
//   START_PC    PC loaded on every honoured start
//   HALT_INSTR  encoding that ends the program
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   start                 launch pulse, honoured in IDLE or HALT only
//   imem_req/addr/ack/rdata  instruction fetch port (addr always equals pc)
//   ir                    held instruction, decoded by Control
//   branchFlag, memToRegFlag, memWriteFlag, regWriteFlag  Control decode of ir
//   branch_taken, branch_target  ALU branch result, sampled in EXEC
//   dmem_req/we/ack       data memory handshake
//   reg_we                register-file write strobe (WB only)
//   pc, done, instr_count program counter, halted flag, retired count
//
// Optional feature
//   CPU_SEQ_CYCLE_COUNT_EN adds cycle_count[31:0]: busy cycles (FETCH..WB)
//   since the last honoured start, saturating, frozen in HALT.

module cpu_sequencer #(
   parameter int              PC_W       = 8,
   parameter logic [PC_W-1:0] START_PC   = '0,
   parameter logic [8:0]      HALT_INSTR = 9'h1FF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [8:0]      imem_rdata,
   output logic [8:0]      ir,
   input  logic            branchFlag,
   input  logic            memToRegFlag,
   input  logic            memWriteFlag,
   input  logic            regWriteFlag,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   output logic            reg_we,
   output logic [PC_W-1:0] pc,
   output logic            done,
`ifdef CPU_SEQ_CYCLE_COUNT_EN
   output logic [31:0]     cycle_count,
`endif
   output logic [15:0]     instr_count
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   state_t            state;
   logic              br_taken_q;
   logic [PC_W-1:0]   br_target_q;
   logic              reg_we_q;

   // Moore outputs straight from the state register; reset forces the state
   // to IDLE asynchronously, so these drop without waiting for an edge.
   assign imem_req  = (state == S_FETCH);
   assign dmem_req  = (state == S_MEM);
   assign done      = (state == S_HALT);
   assign dmem_we   = dmem_req & memWriteFlag;
   assign imem_addr = pc;
   assign reg_we    = reg_we_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         pc          <= '0;
         ir          <= '0;
         instr_count <= '0;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
         reg_we_q    <= 1'b0;
`ifdef CPU_SEQ_CYCLE_COUNT_EN
         cycle_count <= '0;
`endif
      end else begin
         // reg_we is registered on entry to WB so it is high exactly during
         // WB without a combinational path from regWriteFlag.
         reg_we_q <= 1'b0;

`ifdef CPU_SEQ_CYCLE_COUNT_EN
         if (state inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} &&
             cycle_count != 32'hFFFF_FFFF)
            cycle_count <= cycle_count + 32'd1;
`endif

         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc          <= START_PC;
                  instr_count <= '0;
                  state       <= S_FETCH;
`ifdef CPU_SEQ_CYCLE_COUNT_EN
                  cycle_count <= '0;
`endif
               end
            end
            S_FETCH: begin
               if (imem_ack) begin
                  ir    <= imem_rdata;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               state <= (ir == HALT_INSTR) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
               br_taken_q  <= branch_taken;
               br_target_q <= branch_target;
               if (memToRegFlag || memWriteFlag) begin
                  state <= S_MEM;
               end else begin
                  state    <= S_WB;
                  reg_we_q <= regWriteFlag;
               end
            end
            S_MEM: begin
               if (dmem_ack) begin
                  state    <= S_WB;
                  reg_we_q <= regWriteFlag;
               end
            end
            S_WB: begin
               pc <= (branchFlag && br_taken_q) ? br_target_q
                                                : pc + {{(PC_W-1){1'b0}}, 1'b1};
               if (instr_count != 16'hFFFF)
                  instr_count <= instr_count + 16'd1;
               state <= S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed table of instructions with
// hand-computed results, a halt/restart sequence, randomized instructions
// checked against a per-instruction architectural model, and reset mid-MEM.

module tb_cpu_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack = 1'b0;
   logic [8:0] imem_rdata = '0;
   logic [8:0] ir;
   logic       branchFlag = 1'b0, memToRegFlag = 1'b0, memWriteFlag = 1'b0, regWriteFlag = 1'b0;
   logic       branch_taken = 1'b0;
   logic [7:0] branch_target = '0;
   logic       dmem_req, dmem_we;
   logic       dmem_ack = 1'b0;
   logic       reg_we;
   logic [7:0] pc;
   logic       done;
   logic [15:0] instr_count;
`ifdef CPU_SEQ_CYCLE_COUNT_EN
   logic [31:0] cycle_count;
`endif

   always #5 clk = ~clk;

   cpu_sequencer dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .ir(ir),
      .branchFlag(branchFlag), .memToRegFlag(memToRegFlag),
      .memWriteFlag(memWriteFlag), .regWriteFlag(regWriteFlag),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .reg_we(reg_we), .pc(pc), .done(done),
`ifdef CPU_SEQ_CYCLE_COUNT_EN
      .cycle_count(cycle_count),
`endif
      .instr_count(instr_count)
   );

   typedef struct {
      logic [8:0] instr;
      bit         br, m2r, mw, rw, taken;
      logic [7:0] target;
      int         iw, dw;          // fetch / data wait cycles
      logic [7:0] exp_pc;
      int         exp_cnt, exp_lat, exp_we, exp_dreq;
      bit         exp_done;
   } vec_t;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT in FETCH. Plays memory for one
   // instruction and returns once the next fetch (or halt) is visible.
   task automatic run_instr(input vec_t v, input bit noise);
      int lat = 0, iw = v.iw, dw = v.dw, ack_at = 0;
      int nwe = 0, nreq = 0, ndwe = 0;
      bit acked = 0;
      imem_rdata    = v.instr;
      branchFlag    = v.br;
      memToRegFlag  = v.m2r;
      memWriteFlag  = v.mw;
      regWriteFlag  = v.rw;
      branch_taken  = v.taken;
      branch_target = v.target;
      while (1) begin
         if (acked && (imem_req || done)) break;
         if (lat >= 60) begin
            chk("timeout", 1, 0);
            break;
         end
         lat++;
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         // branch inputs only matter in EXEC; scramble them afterwards
         if (acked && lat > ack_at + 2) begin
            branch_taken  = ~v.taken;
            branch_target = ~v.target;
         end
         if (imem_req) begin
            if (iw == 0) begin imem_ack = 1'b1; acked = 1; ack_at = lat; end
            else iw--;
         end
         if (dmem_req) begin
            nreq++;
            if (dmem_we) ndwe++;
            if (dw == 0) dmem_ack = 1'b1; else dw--;
         end
         if (reg_we) nwe++;
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); #1;
         imem_ack = 1'b0; dmem_ack = 1'b0; start = 1'b0;
         @(negedge clk);
      end
      chk("latency", lat, v.exp_lat);
      chk("pc", {24'd0, pc}, {24'd0, v.exp_pc});
      chk("imem_addr", {24'd0, imem_addr}, {24'd0, v.exp_pc});
      chk("instr_count", {16'd0, instr_count}, v.exp_cnt);
      chk("reg_we_cycles", nwe, v.exp_we);
      chk("dmem_req_cycles", nreq, v.exp_dreq);
      chk("dmem_we_cycles", ndwe, v.mw ? v.exp_dreq : 0);
      chk("done", {31'd0, done}, {31'd0, v.exp_done});
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
   endtask

   vec_t tbl[9];
   vec_t v;
   logic [7:0]  m_pc;
   int          m_cnt;
   int          kind, mem;

   initial begin
      tbl[0] = '{9'h003, 0, 0, 0, 1, 0, 8'h00, 0, 0, 8'h01, 1, 4, 1, 0, 0}; // add
      tbl[1] = '{9'h044, 0, 1, 0, 1, 0, 8'h00, 0, 2, 8'h02, 2, 7, 1, 3, 0}; // load, 2 waits
      tbl[2] = '{9'h085, 0, 0, 1, 0, 0, 8'h00, 0, 2, 8'h03, 3, 7, 0, 3, 0}; // store
      tbl[3] = '{9'h0C6, 1, 0, 0, 0, 1, 8'h20, 0, 0, 8'h20, 4, 4, 0, 0, 0}; // br taken
      tbl[4] = '{9'h0C7, 1, 0, 0, 0, 0, 8'h50, 0, 0, 8'h21, 5, 4, 0, 0, 0}; // br not taken
      tbl[5] = '{9'h003, 0, 0, 0, 1, 0, 8'h00, 3, 0, 8'h22, 6, 7, 1, 0, 0}; // fetch waits
      tbl[6] = '{9'h0C8, 1, 0, 0, 0, 1, 8'hFF, 0, 0, 8'hFF, 7, 4, 0, 0, 0}; // br to FF
      tbl[7] = '{9'h003, 0, 0, 0, 1, 1, 8'h40, 0, 0, 8'h00, 8, 4, 1, 0, 0}; // wrap
      tbl[8] = '{9'h1FF, 0, 0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 8, 2, 0, 0, 1}; // halt

      // reset state, asynchronous
      #2;
      chk("rst_imem_req", {31'd0, imem_req}, 0);
      chk("rst_pc", {24'd0, pc}, 0);
      chk("rst_outs", {26'd0, dmem_req, dmem_we, reg_we, done, 2'b00}, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_no_fetch", {31'd0, imem_req}, 0);
      chk("idle_count", {16'd0, instr_count}, 0);

      pulse_start();
      chk("start_fetch", {31'd0, imem_req}, 1);
      for (int i = 0; i < 9; i++) run_instr(tbl[i], 1'b0);

      // halted: stays halted without start
      repeat (3) @(negedge clk);
      chk("halt_hold", {31'd0, done}, 1);
      chk("halt_ir", {23'd0, ir}, 32'h1FF);

      pulse_start();
      chk("restart_done", {31'd0, done}, 0);
      chk("restart_fetch", {31'd0, imem_req}, 1);
      chk("restart_pc", {24'd0, pc}, 0);
      chk("restart_cnt", {16'd0, instr_count}, 0);

      // randomized program against the architectural model
      m_pc = 8'h00;
      m_cnt = 0;
      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 3);
         v.instr  = 9'($urandom_range(0, 510));
         v.br     = (kind == 3);
         v.m2r    = (kind == 1);
         v.mw     = (kind == 2);
         v.rw     = (kind == 0) ? 1'($urandom_range(0, 1)) : (kind == 1);
         v.taken  = 1'($urandom_range(0, 1));
         v.target = 8'($urandom_range(0, 255));
         v.iw     = $urandom_range(0, 3);
         v.dw     = $urandom_range(0, 3);
         mem      = (kind == 1 || kind == 2) ? 1 : 0;
         m_pc     = (v.br && v.taken) ? v.target : 8'(m_pc + 8'd1);
         m_cnt    = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         v.exp_pc   = m_pc;
         v.exp_cnt  = m_cnt;
         v.exp_lat  = 4 + v.iw + (mem ? 1 + v.dw : 0);
         v.exp_we   = v.rw ? 1 : 0;
         v.exp_dreq = mem ? 1 + v.dw : 0;
         v.exp_done = 1'b0;
         run_instr(v, 1'b1);
      end

      // reset in the middle of a MEM access
      imem_rdata = 9'h044; memToRegFlag = 1'b1; memWriteFlag = 1'b0;
      regWriteFlag = 1'b1; branchFlag = 1'b0;
      begin
         int guard = 0;
         while (!dmem_req && guard < 20) begin
            imem_ack = imem_req;
            @(posedge clk); #1; imem_ack = 1'b0;
            @(negedge clk);
            guard++;
         end
         chk("reach_mem", {31'd0, dmem_req}, 1);
      end
      #2 reset = 1'b1;
      #1;
      chk("rst_async_dmem_req", {31'd0, dmem_req}, 0);
      chk("rst_async_pc", {24'd0, pc}, 0);
      chk("rst_async_cnt", {16'd0, instr_count}, 0);
      @(negedge clk);
      reset = 1'b0;
      dmem_ack = 1'b1;
      repeat (2) @(negedge clk);
      dmem_ack = 1'b0;
      chk("post_rst_idle", {29'd0, imem_req, dmem_req, done}, 0);
      chk("post_rst_pc", {24'd0, pc}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
